// File: rtl/wless_tx_buffer.sv
// Wireless TX staging buffer: collects MCU payload bytes in a circular store
// and releases them to UART_node as one burst, either once the fill level
// passes a threshold or once the MCU stream has been quiet for a timeout.
module wless_tx_buffer #(
    parameter int DATA_WIDTH                  = 8,
    parameter int BUFFER_DEPTH                = 512,
    parameter int ADDR_WIDTH                  = 9,
    parameter int START_WIRELESS_TRANS_VALUE  = 57,
    parameter int END_WAITING_SEND_WLESS_DATA = 625000,
    parameter int IDLE_CNT_WIDTH              = 20
) (
    input  logic                  internal_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    input  logic                  wtrans_enable,
    input  logic                  TX_flag_node,
    input  logic                  TX_complete_node,
    output logic [DATA_WIDTH-1:0] data_to_uart_node,
    output logic                  TX_use_node,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  wtrans_active,
    output logic                  aux_ready,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        FLUSH_WAIT
    } state_t;

    localparam logic [ADDR_WIDTH:0]     FULL     = (ADDR_WIDTH+1)'(BUFFER_DEPTH);
    localparam logic [ADDR_WIDTH:0]     THRESH   = (ADDR_WIDTH+1)'(START_WIRELESS_TRANS_VALUE);
    localparam logic [ADDR_WIDTH-1:0]   LAST_PTR = ADDR_WIDTH'(BUFFER_DEPTH - 1);
    localparam logic [IDLE_CNT_WIDTH-1:0] TIMEOUT = IDLE_CNT_WIDTH'(END_WAITING_SEND_WLESS_DATA);

    logic [DATA_WIDTH-1:0]     mem [BUFFER_DEPTH];
    logic [ADDR_WIDTH-1:0]     wr_ptr;
    logic [ADDR_WIDTH-1:0]     rd_ptr;
    logic [IDLE_CNT_WIDTH-1:0] idle_cnt;
    logic                      flush_armed;
    state_t                    state;
    state_t                    next_state;
    logic                      wr_en;
    logic                      pop_en;
    logic [ADDR_WIDTH:0]       next_count;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Accept/pop decisions, next fill level and next FSM state
    always_comb begin
        wr_en      = data_in_valid && (count != FULL);
        // TX_use_node high means a pop happened last cycle; skipping one cycle
        // gives UART_node time to update TX_flag_node before the next push.
        pop_en     = (state == DRAIN) && (count != '0) && wtrans_enable &&
                     !TX_flag_node && !TX_use_node;
        next_count = count;
        if (wr_en && !pop_en)
            next_count = count + 1'b1;
        else if (!wr_en && pop_en)
            next_count = count - 1'b1;

        next_state = state;
        case (state)
            IDLE:
                if (wr_en)
                    next_state = FILL;
            FILL:
                if (wtrans_enable && ((count > THRESH) || (idle_cnt == TIMEOUT)))
                    next_state = DRAIN;
            DRAIN:
                if (count == '0)
                    next_state = FLUSH_WAIT;
            FLUSH_WAIT:
                if (flush_armed && TX_complete_node)
                    next_state = (next_count == '0) ? IDLE : FILL;
            default:
                next_state = IDLE;
        endcase
    end

    // Byte storage; no reset needed since the pointers define valid contents
    always_ff @(posedge internal_clk) begin
        if (wr_en)
            mem[wr_ptr] <= data_in;
    end

    // Pointers, level, FSM, idle timer and registered status/output strobes
    always_ff @(posedge internal_clk) begin
        if (rst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            state             <= IDLE;
            idle_cnt          <= '0;
            flush_armed       <= 1'b0;
            data_to_uart_node <= '0;
            TX_use_node       <= 1'b0;
            wtrans_active     <= 1'b0;
            aux_ready         <= 1'b1;
            overflow          <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_en) begin
                rd_ptr            <= ptr_inc(rd_ptr);
                data_to_uart_node <= mem[rd_ptr];
            end
            TX_use_node <= pop_en;
            count       <= next_count;
            if (data_in_valid && (count == FULL))
                overflow <= 1'b1;
            state <= next_state;
            // TX_complete_node is ignored in the first FLUSH_WAIT cycle, where
            // it may still reflect UART_node status from before the last push.
            flush_armed <= (state == FLUSH_WAIT) && (next_state == FLUSH_WAIT);
            if ((next_state != state) || wr_en)
                idle_cnt <= '0;
            else if ((state == FILL) && (idle_cnt != TIMEOUT))
                idle_cnt <= idle_cnt + 1'b1;
            wtrans_active <= (next_state == DRAIN) || (next_state == FLUSH_WAIT);
            aux_ready     <= (next_state == IDLE) && (next_count == '0);
        end
    end

endmodule

// File: tb/tb_wless_tx_buffer.sv
// Directed bench for wless_tx_buffer; timeout shortened so the run stays short.
module tb_wless_tx_buffer;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_in_valid = 1'b0;
    logic       wtrans_enable = 1'b0;
    logic       TX_flag_node = 1'b0;
    logic       TX_complete_node = 1'b0;
    logic [7:0] data_to_uart_node;
    logic       TX_use_node;
    logic [9:0] count;
    logic       wtrans_active;
    logic       aux_ready;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int gap_err = 0;
    int cyc = 0;
    int last_pulse = -100;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    wless_tx_buffer #(
        .DATA_WIDTH(8),
        .BUFFER_DEPTH(512),
        .ADDR_WIDTH(9),
        .START_WIRELESS_TRANS_VALUE(57),
        .END_WAITING_SEND_WLESS_DATA(TMO),
        .IDLE_CNT_WIDTH(20)
    ) dut (
        .internal_clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .wtrans_enable(wtrans_enable),
        .TX_flag_node(TX_flag_node),
        .TX_complete_node(TX_complete_node),
        .data_to_uart_node(data_to_uart_node),
        .TX_use_node(TX_use_node),
        .count(count),
        .wtrans_active(wtrans_active),
        .aux_ready(aux_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Capture every push to UART_node and flag pushes closer than 2 cycles apart
    always @(negedge clk) begin
        if (TX_use_node === 1'b1) begin
            if (cyc - last_pulse < 2)
                gap_err++;
            last_pulse = cyc;
            rx_q.push_back(data_to_uart_node);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_in       = b;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, rx_q.size(), n);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) begin
                chk({tag, "_byte"}, {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
                break;
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_flush(input string tag);
        repeat (3) tick();
        chk({tag, "_fw_active"}, wtrans_active, 1);
        chk({tag, "_fw_aux"}, aux_ready, 0);
        chk({tag, "_fw_count"}, count, 0);
        TX_complete_node = 1'b1;
        tick();
        TX_complete_node = 1'b0;
        chk({tag, "_idle_active"}, wtrans_active, 0);
        chk({tag, "_idle_aux"}, aux_ready, 1);
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_aux", aux_ready, 1);
        chk("rst_active", wtrans_active, 0);
        chk("rst_use", TX_use_node, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", data_to_uart_node, 0);

        // Threshold burst: 58 bytes 0x00..0x39
        wtrans_enable = 1'b1;
        for (int i = 0; i < 58; i++) begin
            write_byte(8'(i));
            exp_q.push_back(8'(i));
            if (i == 56) chk("t1_fill57_active", wtrans_active, 0);
        end
        chk("t1_count58", count, 58);
        chk("t1_still_fill", wtrans_active, 0);
        tick();
        chk("t1_drain_entry", wtrans_active, 1);
        wait_rx("t1_wait", 58, 400);
        check_rx("t1_data");
        finish_flush("t1");

        // Idle-timeout burst: 5 bytes then silence
        for (int i = 0; i < 5; i++) begin
            write_byte(8'hA1 + 8'(i));
            exp_q.push_back(8'hA1 + 8'(i));
        end
        chk("t2_count5", count, 5);
        repeat (TMO) tick();
        chk("t2_fill_at_tmo", wtrans_active, 0);
        chk("t2_no_push", rx_q.size(), 0);
        tick();
        chk("t2_drain_after_tmo", wtrans_active, 1);
        wait_rx("t2_wait", 5, 100);
        check_rx("t2_data");
        finish_flush("t2");

        // TX_flag_node back-pressure in DRAIN
        for (int i = 0; i < 60; i++) begin
            write_byte(8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
        end
        wait_rx("t3_wait4", 4, 100);
        TX_flag_node = 1'b1;
        chk("t3_count_at_hold", count, 56);
        repeat (100) tick();
        chk("t3_count_frozen", count, 56);
        chk("t3_rx_frozen", rx_q.size(), 4);
        chk("t3_no_use", TX_use_node, 0);
        TX_flag_node = 1'b0;
        wait_rx("t3_wait", 60, 400);
        check_rx("t3_data");
        finish_flush("t3");

        // Fill to 512 with transmit disabled, then overflow
        wtrans_enable = 1'b0;
        for (int i = 0; i < 512; i++) begin
            write_byte(8'(i) ^ 8'h5A);
            exp_q.push_back(8'(i) ^ 8'h5A);
        end
        chk("t4_count_full", count, 512);
        chk("t4_ovf_before", overflow, 0);
        chk("t4_aux_full", aux_ready, 0);
        write_byte(8'hFF);
        chk("t4_count_held", count, 512);
        chk("t4_ovf_set", overflow, 1);
        wtrans_enable = 1'b1;
        wait_rx("t4_wait", 512, 1300);
        check_rx("t4_data");
        chk("t4_ovf_sticky", overflow, 1);
        finish_flush("t4");

        // Write coinciding with pop, across pointer wrap (wr_ptr reaches 511)
        wtrans_enable = 1'b0;
        for (int i = 0; i < 388; i++) begin
            write_byte(8'(i * 7 + 3));
            exp_q.push_back(8'(i * 7 + 3));
        end
        wtrans_enable = 1'b1;
        tick();
        chk("t5_drain", wtrans_active, 1);
        chk("t5_count_pre", count, 388);
        write_byte(8'hC0);
        chk("t5_count_same", count, 388);
        chk("t5_pop_pulse", TX_use_node, 1);
        for (int i = 1; i < 4; i++) write_byte(8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hC0 + 8'(i));
        chk("t5_count_post", count, 390);
        wait_rx("t5_wait", 392, 1000);
        check_rx("t5_data");
        finish_flush("t5");

        // Reset in the middle of a burst
        wtrans_enable = 1'b0;
        for (int i = 0; i < 60; i++) write_byte(8'h20 + 8'(i));
        wtrans_enable = 1'b1;
        wait_rx("t6_wait30", 30, 200);
        chk("t6_count30", count, 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx_q.delete();
        chk("t6_count", count, 0);
        chk("t6_active", wtrans_active, 0);
        chk("t6_use", TX_use_node, 0);
        chk("t6_aux", aux_ready, 1);
        chk("t6_ovf", overflow, 0);
        repeat (10) tick();
        chk("t6_quiet", rx_q.size(), 0);
        chk("t6_aux_hold", aux_ready, 1);

        chk("push_spacing", gap_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wless_tx_buffer.md
Name: wless_tx_buffer

Overview:
- 512-byte staging buffer between the MCU-side UART receive path and the UART_node transmitter.
- Collects payload bytes from the MCU, then releases them to UART_node as a burst (one wireless transmission).
- A burst starts when the fill level passes a threshold, or when the MCU stream goes idle for a timeout.
- Reports busy/ready for AUX generation, plus overflow.

Parameters:
DATA_WIDTH, 8, byte width
BUFFER_DEPTH, 512, storage entries
ADDR_WIDTH, 9, pointer width (log2 BUFFER_DEPTH)
START_WIRELESS_TRANS_VALUE, 57, burst starts once count > this value (i.e. >= 58)
END_WAITING_SEND_WLESS_DATA, 625000, idle cycles after last write before a partial burst is forced
IDLE_CNT_WIDTH, 20, idle timer width

Ports:
internal_clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
data_in  in  DATA_WIDTH  byte from MCU UART receive path
data_in_valid  in  1  one-cycle write strobe
wtrans_enable  in  1  high = wireless transmit permitted (mode allows it)
TX_flag_node  in  1  high = UART_node TX FIFO full, do not push
TX_complete_node  in  1  high = UART_node has shifted out everything
data_to_uart_node  out  DATA_WIDTH  byte presented to UART_node
TX_use_node  out  1  one-cycle push strobe to UART_node
count  out  ADDR_WIDTH+1  bytes currently held (0..512)
wtrans_active  out  1  high in DRAIN or FLUSH_WAIT
aux_ready  out  1  high only in IDLE with count==0
overflow  out  1  sticky: a write arrived while full

Behaviour:
- Reset (rst high at an edge) forces: pointers=0, count=0, state=IDLE, idle timer=0, data_to_uart_node=0, TX_use_node=0, wtrans_active=0, aux_ready=1, overflow=0.
- Reset has priority over every other event. A burst in flight is abandoned and buffered data discarded.
- Circular storage. Pointers wrap from BUFFER_DEPTH-1 to 0.
- Write occurs when data_in_valid=1 and count<BUFFER_DEPTH. Byte is stored at wr_ptr; wr_ptr++; count++.
- Write when count==BUFFER_DEPTH: byte dropped, overflow set (held until rst), state/count unchanged.
- Pop, same cycle: read rd_ptr, rd_ptr++, count--.
  - Next cycle: data_to_uart_node = popped byte, TX_use_node=1 for exactly one cycle.
  - data_to_uart_node holds until the next pop.
- Simultaneous write and pop: count unchanged, both pointers advance.
- Pops are never issued on consecutive cycles. At least one idle cycle follows each TX_use_node pulse so TX_flag_node can update.
- Idle timer:
  - Cleared on every accepted write and on every state entry.
  - Increments each cycle in FILL.
  - Saturates at END_WAITING_SEND_WLESS_DATA.
- FSM states:
  - IDLE: count==0. Accepted write -> FILL.
  - FILL: if wtrans_enable and (count > START_WIRELESS_TRANS_VALUE, or timer == END_WAITING_SEND_WLESS_DATA) -> DRAIN. Otherwise stay.
  - DRAIN:
    - Pop when count!=0, wtrans_enable=1, TX_flag_node=0 and no pulse in the previous cycle.
    - wtrans_enable low suspends pops without leaving DRAIN.
    - count reaches 0 (after the last pop) -> FLUSH_WAIT.
    - Writes continue to be accepted and join the current burst.
  - FLUSH_WAIT:
    - No pops.
    - When TX_complete_node=1 (sampled no earlier than the cycle after entry) -> IDLE if count==0, else FILL.
    - Writes still accepted.
- Threshold check uses the registered count, so the write that raises count to 58 causes DRAIN entry on the following cycle.
- wtrans_active = (state==DRAIN or FLUSH_WAIT), registered with the state.
- aux_ready = (next_state==IDLE and next_count==0), registered.

Test Plan:
- Reset, then write 58 bytes 0x00..0x39 with wtrans_enable=1, TX_flag_node=0 -> DRAIN one cycle after 58th write; 58 TX_use_node pulses spaced >=2 cycles; data_to_uart_node 0x00..0x39 in order; count ends 0; FLUSH_WAIT; TX_complete_node=1 -> IDLE, aux_ready=1.
- Write 5 bytes (0xA1..0xA5), then silence -> stays FILL for exactly END_WAITING_SEND_WLESS_DATA cycles after last write, then drains 0xA1..0xA5.
- Hold TX_flag_node=1 during DRAIN for 100 cycles -> no TX_use_node pulses, count frozen; release -> draining resumes with next byte, no loss or duplication.
- Fill 512 bytes with wtrans_enable=0, write byte 0xFF -> count stays 512, overflow=1; enable -> 512 bytes drained, overflow still 1 until rst.
- Write during DRAIN on same cycle as a pop -> count unchanged; new byte sent after older bytes, including across pointer wrap at 511->0.
- Assert rst mid-DRAIN with count=30 -> next cycle count=0, state IDLE, TX_use_node=0, aux_ready=1, overflow=0.
